// File: rtl/updn_mod_cntr.sv
// Synchronous up/down modulo-MOD_VAL counter with load, wrap/saturate mode and tc/wrap/ovf status.
// Latency: count/wrap/ovf one edge after inputs sampled, tc combinational; no backpressure, steps whenever en=1.
module updn_mod_cntr #(
  parameter int WIDTH    = 4,
  parameter int MOD_VAL  = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MOD_VAL - 1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_ovf;

  logic             w_at_max;
  logic             w_at_zero;
  logic             w_tc;
  logic             w_event;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_next_up;
  logic [WIDTH-1:0] w_next_dn;
  logic [WIDTH-1:0] w_step_val;

  assign w_at_max  = (r_count == MAX_CNT);
  assign w_at_zero = (r_count == '0);
  assign w_tc      = up_dn ? w_at_max : w_at_zero;

  // A blocked saturating step counts as a boundary event just like a wrap.
  assign w_event = en & ~load & w_tc;

  assign w_load_clamped = (load_val > MAX_CNT) ? MAX_CNT : load_val;

  assign w_next_up  = w_at_max  ? (SATURATE ? MAX_CNT : '0) : r_count + 1'b1;
  assign w_next_dn  = w_at_zero ? (SATURATE ? '0 : MAX_CNT) : r_count - 1'b1;
  assign w_step_val = up_dn ? w_next_up : w_next_dn;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (load) begin
        r_count <= w_load_clamped;
      end else if (en) begin
        r_count <= w_step_val;
      end
      r_wrap <= w_event;
      // Set has priority so an event coinciding with a clear is never lost.
      if (w_event) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign count = r_count;
  assign tc    = w_tc;
  assign wrap  = r_wrap;
  assign ovf   = r_ovf;

endmodule
